// File: rtl/rs232_rx_packet_buffer_pkg.sv
// Shared types for the RS-232 receive packet buffer: byte width, default depth,
// storage entry record and the write-side accept/drop state.
package rs232_rx_packet_buffer_pkg;

  localparam int RX_BYTE_W      = 8;
  localparam int DEF_DEPTH_LOG2 = 6;

  typedef struct packed {
    logic                 last;
    logic [RX_BYTE_W-1:0] data;
  } rx_entry_t;

  typedef enum logic {
    RX_ACCEPT = 1'b0,
    RX_DROP   = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rs232_rx_packet_buffer_if.sv
// Byte ingress from the UART receiver and packet egress stream toward the consumer.
// master = producer/consumer side, slave = the packet buffer.
interface rs232_rx_packet_buffer_if;
  import rs232_rx_packet_buffer_pkg::*;

  logic                 rx_dataout_ready;
  logic [RX_BYTE_W-1:0] rx_dataout;
  logic                 rx_endofpacket;
  logic [RX_BYTE_W-1:0] m_data;
  logic                 m_valid;
  logic                 m_last;
  logic                 m_ready;

  modport master (
    output rx_dataout_ready, rx_dataout, rx_endofpacket, m_ready,
    input  m_data, m_valid, m_last
  );

  modport slave (
    input  rx_dataout_ready, rx_dataout, rx_endofpacket, m_ready,
    output m_data, m_valid, m_last
  );
endinterface

// File: rtl/rs232_fifo_ram.sv
// Packet buffer storage: single write port, asynchronous read.
// Write lands on the clock edge; read data follows the address combinationally.
module rs232_fifo_ram
  import rs232_rx_packet_buffer_pkg::*;
#(
  parameter int AW = DEF_DEPTH_LOG2
) (
  input  logic          clock,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  rx_entry_t     i_wr_dat,
  input  logic [AW-1:0] i_rd_addr,
  output rx_entry_t     o_rd_dat
);

  rx_entry_t r_mem [2**AW];

  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/rs232_rx_packet_buffer.sv
// Store-and-forward byte FIFO: packets appear on m_* one cycle after their end-of-packet.
// Oversize or overflowing packets are dropped whole; m_ready only gates the read side.
module rs232_rx_packet_buffer
  import rs232_rx_packet_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int MAX_PKT_LEN = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    Exe_LogicImp,
  rs232_rx_packet_buffer_if.slave bus,
  output logic [DEPTH_LOG2:0]     pkt_pending,
  output logic [DEPTH_LOG2:0]     fifo_level,
  output logic                    pkt_dropped
);

  localparam int             PW      = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0]  ONE     = PW'(1);
  localparam logic [PW-1:0]  DEPTH   = PW'(2**DEPTH_LOG2);
  localparam logic [PW-1:0]  MAX_LEN = PW'(MAX_PKT_LEN);

  logic [PW-1:0]        r_wr_ptr, r_commit_ptr, r_rd_ptr, r_pkt_pending;
  logic                 r_pkt_dropped;
  logic [RX_BYTE_W-1:0] r_last_byte;
  rx_state_e            r_state, w_state_nxt;

  logic [PW-1:0]        w_level, w_cur_len, w_wr_ptr_nxt, w_wr_ptr_m1;
  logic                 w_full, w_m_valid, w_rd_en, w_wr_try, w_overrun, w_wr_en;
  logic                 w_drop_eop, w_commit, w_fix_last, w_ram_we, w_clr;
  logic [DEPTH_LOG2-1:0] w_ram_addr;
  rx_entry_t            w_ram_wdat, w_rd_dat;

  assign w_clr        = reset || Exe_LogicImp;
  assign w_level      = r_wr_ptr - r_rd_ptr;
  assign w_cur_len    = r_wr_ptr - r_commit_ptr;
  assign w_full       = (w_level == DEPTH);
  assign w_m_valid    = (r_rd_ptr != r_commit_ptr);
  assign w_rd_en      = w_m_valid && bus.m_ready;

  assign w_wr_try     = bus.rx_dataout_ready && (r_state == RX_ACCEPT);
  assign w_overrun    = w_wr_try && (w_full || (w_cur_len == MAX_LEN));
  assign w_wr_en      = w_wr_try && !w_overrun;
  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_en);
  assign w_wr_ptr_m1  = r_wr_ptr - ONE;

  // A byte that overruns in the same cycle as end-of-packet still discards the packet.
  assign w_drop_eop   = bus.rx_endofpacket && ((r_state == RX_DROP) || w_overrun);
  assign w_commit     = bus.rx_endofpacket && !w_drop_eop && (w_wr_ptr_nxt != r_commit_ptr);
  assign w_fix_last   = w_commit && !w_wr_en;

  // Late end-of-packet re-writes the previous byte (held in r_last_byte) with its last bit set.
  always_comb begin
    w_ram_we   = w_wr_en || w_fix_last;
    w_ram_addr = r_wr_ptr[DEPTH_LOG2-1:0];
    w_ram_wdat = '{last: bus.rx_endofpacket, data: bus.rx_dataout};
    if (!w_wr_en) begin
      w_ram_addr = w_wr_ptr_m1[DEPTH_LOG2-1:0];
      w_ram_wdat = '{last: 1'b1, data: r_last_byte};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_drop_eop)     w_state_nxt = RX_ACCEPT;
    else if (w_overrun) w_state_nxt = RX_DROP;
  end

  always_ff @(posedge clock) begin
    if (w_clr) r_state <= RX_ACCEPT;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_wr_ptr      <= '0;
      r_commit_ptr  <= '0;
      r_rd_ptr      <= '0;
      r_pkt_pending <= '0;
      r_pkt_dropped <= 1'b0;
    end else begin
      r_pkt_dropped <= w_drop_eop;
      if (w_rd_en)    r_rd_ptr     <= r_rd_ptr + ONE;
      if (w_drop_eop) r_wr_ptr     <= r_commit_ptr;
      else            r_wr_ptr     <= w_wr_ptr_nxt;
      if (w_commit)   r_commit_ptr <= w_wr_ptr_nxt;
      r_pkt_pending <= r_pkt_pending + PW'(w_commit) - PW'(w_rd_en && w_rd_dat.last);
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) r_last_byte <= bus.rx_dataout;
  end

  rs232_fifo_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clock     (clock),
    .i_wr_en   (w_ram_we),
    .i_wr_addr (w_ram_addr),
    .i_wr_dat  (w_ram_wdat),
    .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rd_dat  (w_rd_dat)
  );

  assign bus.m_data  = w_rd_dat.data;
  assign bus.m_last  = w_rd_dat.last;
  assign bus.m_valid = w_m_valid;
  assign pkt_pending = r_pkt_pending;
  assign fifo_level  = w_level;
  assign pkt_dropped = r_pkt_dropped;

endmodule

// File: tb/tb_rs232_rx_packet_buffer.sv
// Bench for rs232_rx_packet_buffer: directed packet scenarios then randomized traffic,
// every cycle compared against a queue-based packet model.
module tb_rs232_rx_packet_buffer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       exe   = 1'b0;
  logic [6:0] pkt_pending;
  logic [6:0] fifo_level;
  logic       pkt_dropped;

  rs232_rx_packet_buffer_if bus ();

  rs232_rx_packet_buffer #(.DEPTH_LOG2(6), .MAX_PKT_LEN(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .Exe_LogicImp (exe),
    .bus          (bus),
    .pkt_pending  (pkt_pending),
    .fifo_level   (fifo_level),
    .pkt_dropped  (pkt_dropped)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errs    = 0;

  // Model: committed-but-unread bytes as {last,data}, plus the packet being assembled.
  logic [8:0] q_comm[$];
  logic [7:0] q_cur[$];
  bit         m_drop    = 1'b0;
  int         m_pend    = 0;
  bit         m_dropped = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic rdy, input logic [7:0] d, input logic eop,
                              input logic mr, input logic clr);
    int         lvl;
    logic [8:0] h;
    if (clr) begin
      q_comm.delete();
      q_cur.delete();
      m_drop    = 1'b0;
      m_pend    = 0;
      m_dropped = 1'b0;
      return;
    end
    lvl       = q_comm.size() + q_cur.size();
    m_dropped = 1'b0;
    if (mr && q_comm.size() != 0) begin
      h = q_comm.pop_front();
      if (h[8]) m_pend--;
    end
    if (rdy && !m_drop) begin
      if (lvl == 64 || q_cur.size() == 32) m_drop = 1'b1;
      else q_cur.push_back(d);
    end
    if (eop) begin
      if (m_drop) begin
        q_cur.delete();
        m_drop    = 1'b0;
        m_dropped = 1'b1;
      end else if (q_cur.size() != 0) begin
        foreach (q_cur[i]) q_comm.push_back({i == q_cur.size() - 1, q_cur[i]});
        q_cur.delete();
        m_pend++;
      end
    end
  endtask

  // Called at a negedge: check outputs, drive inputs, advance one clock.
  task automatic step(input logic rdy, input logic [7:0] d, input logic eop,
                      input logic mr, input logic clr, input logic rst);
    logic [8:0] h;
    chk("m_valid",     32'(bus.m_valid),  32'(q_comm.size() != 0));
    chk("fifo_level",  32'(fifo_level),   32'(q_comm.size() + q_cur.size()));
    chk("pkt_pending", 32'(pkt_pending),  32'(m_pend));
    chk("pkt_dropped", 32'(pkt_dropped),  32'(m_dropped));
    if (q_comm.size() != 0) begin
      h = q_comm[0];
      chk("m_data", 32'(bus.m_data), 32'(h[7:0]));
      chk("m_last", 32'(bus.m_last), 32'(h[8]));
    end
    bus.rx_dataout_ready = rdy;
    bus.rx_dataout       = d;
    bus.rx_endofpacket   = eop;
    bus.m_ready          = mr;
    exe                  = clr;
    reset                = rst;
    @(posedge clock);
    model_update(rdy, d, eop, mr, clr || rst);
    @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d, input logic mr);
    step(1'b1, d, 1'b0, mr, 1'b0, 1'b0);
  endtask

  task automatic eop_only(input logic mr);
    step(1'b0, 8'h00, 1'b1, mr, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, mr, 1'b0, 1'b0);
  endtask

  initial begin
    bus.rx_dataout_ready = 1'b0;
    bus.rx_dataout       = 8'h00;
    bus.rx_endofpacket   = 1'b0;
    bus.m_ready          = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_m_valid",     32'(bus.m_valid), 32'd0);
    chk("rst_fifo_level",  32'(fifo_level),  32'd0);
    chk("rst_pkt_pending", 32'(pkt_pending), 32'd0);
    chk("rst_pkt_dropped", 32'(pkt_dropped), 32'd0);

    // 41,42,43 then end-of-packet, drained immediately
    send(8'h41, 1'b1); send(8'h42, 1'b1); send(8'h43, 1'b1);
    eop_only(1'b1);
    chk("pkt0_head", 32'(bus.m_data), 32'h41);
    idle(5, 1'b1);

    // five bytes held back until end-of-packet
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b0);
    idle(2, 1'b0);
    chk("uncommitted_level", 32'(fifo_level), 32'd5);
    eop_only(1'b0);
    chk("commit_pending", 32'(pkt_pending), 32'd1);
    idle(8, 1'b1);

    // oversize packet dropped, next packet intact
    for (int i = 0; i < 33; i++) send(8'(i), 1'b1);
    eop_only(1'b1);
    chk("oversize_drop", 32'(pkt_dropped), 32'd1);
    send(8'h55, 1'b1);
    eop_only(1'b1);
    idle(4, 1'b1);

    // two 30-byte packets then a 10-byte packet overflowing 64 entries
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 30; i++) send(8'(8'h80 + p * 32 + i), 1'b0);
      eop_only(1'b0);
    end
    for (int i = 0; i < 10; i++) send(8'(8'hE0 + i), 1'b0);
    chk("full_level", 32'(fifo_level), 32'd64);
    eop_only(1'b0);
    chk("overflow_drop", 32'(pkt_dropped), 32'd1);
    idle(65, 1'b1);

    // empty eop, then byte with eop in the same cycle
    eop_only(1'b1);
    step(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("same_cycle_last", 32'(bus.m_last), 32'd1);
    idle(3, 1'b1);

    // soft clear with a committed packet queued and another mid-assembly
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); eop_only(1'b0);
    send(8'hB1, 1'b0); send(8'hB2, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_m_valid", 32'(bus.m_valid), 32'd0);
    chk("clr_level",   32'(fifo_level),  32'd0);
    send(8'hC1, 1'b1); send(8'hC2, 1'b1); eop_only(1'b1);
    idle(4, 1'b1);

    // randomized traffic in phases of differing packet length and consumer rate
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 800; i++) begin
        logic rdy, eop, mr, clr, rst;
        rdy = ($urandom % 3) == 0;
        eop = ($urandom % ((ph == 1) ? 60 : 10)) == 0;
        mr  = (ph == 2) ? (($urandom % 8) == 0) : (($urandom % 4) != 0);
        clr = (ph == 3) && (($urandom % 300) == 0);
        rst = (ph == 3) && (($urandom % 400) == 0);
        step(rdy, 8'($urandom), eop, mr, clr, rst);
      end
    end
    idle(70, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/rs232_rx_packet_buffer.md
Name: rs232_rx_packet_buffer

Overview:
- Store-and-forward byte FIFO directly downstream of the RS-232 receiver.
- Accepts received bytes (data + ready strobe) and the receiver's end-of-packet pulse.
- Groups bytes into packets; a packet becomes visible on the output stream only after its end-of-packet commit.
- Oversize or overflowing packets are dropped whole; the consumer (command parser / host bridge) sees only complete packets, via a valid/ready stream with a last-byte marker.

Parameters:
- DEPTH_LOG2, 6, log2 of FIFO byte capacity (DEPTH = 64 bytes).
- MAX_PKT_LEN, 32, max bytes per packet; byte MAX_PKT_LEN+1 triggers a drop. Legal range 1..DEPTH.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- Exe_LogicImp  in  1  synchronous soft clear; same effect as reset.
- rx_dataout_ready  in  1  one-cycle strobe: rx_dataout is a valid received byte.
- rx_dataout  in  8  received byte.
- rx_endofpacket  in  1  one-cycle pulse: line idle, current packet ends.
- m_data  out  8  head byte, combinational from FIFO storage at read pointer.
- m_valid  out  1  at least one committed byte is available.
- m_last  out  1  head byte is the final byte of its packet.
- m_ready  in  1  consumer accepts head byte when m_valid && m_ready.
- pkt_pending  out  DEPTH_LOG2+1  number of committed, not fully read packets.
- fifo_level  out  DEPTH_LOG2+1  bytes held (committed + uncommitted).
- pkt_dropped  out  1  one-cycle pulse when a packet is discarded.

Behaviour:
- Reset / Exe_LogicImp clears all pointers to 0, pkt_pending=0, drop state=0 and pkt_dropped=0. m_valid=0 and fifo_level=0 follow. Storage contents are not cleared. Exe_LogicImp has priority over every other event.
- Pointers: wr_ptr, commit_ptr and rd_ptr, each DEPTH_LOG2+1 bits with natural wrap. Storage is indexed by the low DEPTH_LOG2 bits. Each entry holds 8 data bits plus 1 last bit.
- Derived signals:
  - full = (wr_ptr - rd_ptr == DEPTH)
  - m_valid = (rd_ptr != commit_ptr)
  - fifo_level = wr_ptr - rd_ptr
  - cur_len = wr_ptr - commit_ptr
- Write, on rx_dataout_ready and not dropping:
  - If full, or cur_len == MAX_PKT_LEN: enter dropping. The byte is not written.
  - Otherwise write {last=rx_endofpacket, data} and increment wr_ptr.
- While dropping, all incoming bytes are discarded.
- Commit, on rx_endofpacket:
  - If dropping: wr_ptr <= commit_ptr (rewind), dropping <= 0, pkt_dropped=1 next cycle.
  - Else if cur_len (including any same-cycle written byte) > 0: set the last bit of entry wr_ptr-1 (or of the same-cycle byte), commit_ptr <= new wr_ptr, pkt_pending += 1.
  - Else (empty packet): ignore, no pulse.
- Read: on m_valid && m_ready, rd_ptr += 1. If m_last was high, pkt_pending -= 1.
- Simultaneous commit and last-byte read leave pkt_pending unchanged.
- A read and a write in the same cycle are both honoured. full is evaluated before that cycle's read, so no write is allowed into a slot being freed.
- m_ready while !m_valid has no effect.
- Committed data is never overwritten; only uncommitted bytes are rewound.
- Latency: a committed byte appears at m_valid the cycle after the rx_endofpacket edge.

Decomposition:
- Shared package holds the RS-232 byte width (8), the default FIFO depth constant, and the entry record {last, data[7:0]}.
- One natural sub-module: rs232_fifo_ram. It is a DEPTH x 9 single-write, asynchronous-read storage array. The pointer and commit logic stays in the top.

Test Plan:
- Packet 0x41,0x42,0x43 then eop, m_ready=1 -> m_data 41,42,43 on successive cycles. m_last=1 only on 0x43. pkt_pending goes 0→1→0.
- 5 bytes with eop not yet received -> m_valid stays 0 and fifo_level=5. After eop -> m_valid=1 next cycle and pkt_pending=1.
- 33 bytes then eop (MAX_PKT_LEN=32) -> pkt_dropped pulses once. fifo_level returns to its prior value, m_valid=0, and the next packet 0x55 is delivered intact.
- m_ready=0, two 30-byte packets committed, third packet of 10 bytes -> FIFO fills at 64 and the third packet is dropped. The first two are then read out intact with pkt_pending 2→1→0.
- eop with no pending bytes -> no state change, no pulse. Byte 0x7E with rx_endofpacket in the same cycle -> 0x7E committed with m_last=1.
- Exe_LogicImp asserted mid-packet with a committed packet queued -> next cycle m_valid=0, fifo_level=0, pkt_pending=0, and subsequent packets are delivered normally.
